// File: rtl/pipelined_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_cpu_core
// Description : Two-stage (IF / EX) 16-bit-ISA core with register bank,
//               internal call/data stack, status flags, sticky stack-fault
//               detection and a halt state. Instruction memory is external
//               with a combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_cpu_core #(
  parameter int DATA_W      = 16,
  parameter int PC_W        = 5,
  parameter int NREG        = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [DATA_W-1:0] out,
  output logic [3:0]        flags,
  output logic              halted,
  output logic              stack_err
);

  localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_BNZ  = 4'hA;
  localparam logic [3:0] OP_BC   = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hC;
  localparam logic [3:0] OP_RET  = 4'hD;
  localparam logic [3:0] OP_PUSH = 4'hE;
  localparam logic [3:0] OP_POP  = 4'hF;

  localparam logic [15:0] IR_NOP = 16'h0000;

  // Architectural / pipeline state
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs  [0:NREG-1];
  logic [DATA_W-1:0] stack [0:STACK_DEPTH-1];
  logic [SPW-1:0]    sp;

  // EX-stage decode
  logic [3:0]        op;
  logic [RIW-1:0]    rd_idx, rs_idx;
  logic [DATA_W-1:0] rd_val, rs_val, stack_top;
  logic [PC_W-1:0]   tgt;
  logic              stack_full, stack_empty;

  assign imem_addr   = pc;
  assign op          = ir[15:12];
  assign rd_idx      = RIW'({29'd0, ir[11:9]} % NREG);
  assign rs_idx      = RIW'({29'd0, ir[8:6]} % NREG);
  assign rd_val      = regs[rd_idx];
  assign rs_val      = regs[rs_idx];
  assign tgt         = ir[PC_W-1:0];
  assign stack_top   = stack[SIW'(sp - SPW'(1))];
  assign stack_full  = (sp == SPW'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  // EX-stage results
  logic [DATA_W-1:0] res, wr_val, push_val;
  logic [PC_W-1:0]   pc_next;
  logic              carry, ovf, set_flags, wr_en, flush;
  logic              do_push, do_pop, stop, fault;

  // Decode the instruction in IR and work out everything it commits at the next edge
  always_comb begin
    res       = '0;
    wr_val    = '0;
    push_val  = '0;
    pc_next   = pc + PC_W'(1);
    carry     = 1'b0;
    ovf       = 1'b0;
    set_flags = 1'b0;
    wr_en     = 1'b0;
    flush     = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    stop      = 1'b0;
    fault     = 1'b0;
    case (op)
      OP_ADD: begin
        {carry, res} = {1'b0, rd_val} + {1'b0, rs_val};
        ovf          = (rd_val[MSB] == rs_val[MSB]) && (res[MSB] != rd_val[MSB]);
        set_flags    = 1'b1;
      end
      OP_SUB: begin
        res       = rd_val - rs_val;
        carry     = (rd_val < rs_val);
        ovf       = (rd_val[MSB] != rs_val[MSB]) && (res[MSB] != rd_val[MSB]);
        set_flags = 1'b1;
      end
      OP_AND: begin res = rd_val & rs_val; set_flags = 1'b1; end
      OP_OR:  begin res = rd_val | rs_val; set_flags = 1'b1; end
      OP_XOR: begin res = rd_val ^ rs_val; set_flags = 1'b1; end
      OP_LDI: begin wr_en = 1'b1; wr_val = DATA_W'(ir[7:0]); end
      OP_MOV: begin wr_en = 1'b1; wr_val = rs_val; end
      OP_JMP: begin pc_next = tgt; flush = 1'b1; end
      OP_BZ:  if (flags[2])  begin pc_next = tgt; flush = 1'b1; end
      OP_BNZ: if (!flags[2]) begin pc_next = tgt; flush = 1'b1; end
      OP_BC:  if (flags[3])  begin pc_next = tgt; flush = 1'b1; end
      OP_CALL: begin
        // pc already points one past the instruction in EX: that is the return address
        if (stack_full) fault = 1'b1;
        else begin
          do_push  = 1'b1;
          push_val = DATA_W'(pc);
          pc_next  = tgt;
          flush    = 1'b1;
        end
      end
      OP_RET: begin
        if (stack_empty) fault = 1'b1;
        else begin
          do_pop  = 1'b1;
          pc_next = stack_top[PC_W-1:0];
          flush   = 1'b1;
        end
      end
      OP_PUSH: begin
        if (stack_full) fault = 1'b1;
        else begin
          do_push  = 1'b1;
          push_val = rs_val;
        end
      end
      OP_POP: begin
        if (ir[0]) stop = 1'b1;
        else if (stack_empty) fault = 1'b1;
        else begin
          do_pop = 1'b1;
          wr_en  = 1'b1;
          wr_val = stack_top;
        end
      end
      default: ;
    endcase
    if (set_flags) begin
      wr_en  = 1'b1;
      wr_val = res;
    end
  end

  // Fetch, commit EX results, and freeze everything once halted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      ir        <= IR_NOP;
      sp        <= '0;
      out       <= '0;
      flags     <= '0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
      for (int i = 0; i < NREG; i++)        regs[i]  <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (!halted) begin
      if (stop || fault) begin
        halted <= 1'b1;
        ir     <= IR_NOP;
        if (fault) stack_err <= 1'b1;
      end else begin
        pc <= pc_next;
        ir <= flush ? IR_NOP : imem_data;
        if (wr_en) begin
          regs[rd_idx] <= wr_val;
          out          <= wr_val;
        end
        if (set_flags) flags <= {carry, (res == '0), res[MSB], ovf};
        if (do_push) begin
          stack[SIW'(sp)] <= push_val;
          sp              <= sp + SPW'(1);
        end
        if (do_pop) sp <= sp - SPW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cpu_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_cpu_core
// Description : Self-checking bench for pipelined_cpu_core (8-bit data,
//               5-bit PC, 8 registers, 2-entry stack). An instruction-level
//               reference model with a one-slot execute window predicts every
//               cycle; directed programs plus random programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_cpu_core;

  localparam int DW    = 8;
  localparam int PW    = 5;
  localparam int DEPTH = 2;
  localparam int MASK  = (1 << DW) - 1;
  localparam int HALF  = 1 << (DW - 1);
  localparam int NADDR = 1 << PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [PW-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic [DW-1:0] out;
  logic [3:0]    flags;
  logic          halted;
  logic          stack_err;

  logic [15:0] mem [0:NADDR-1];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_r [0:7];
  int m_c, m_z, m_s, m_v;
  int m_out, m_halt, m_err;
  int m_stk [$];
  int m_fpc, m_exa, m_exv;

  pipelined_cpu_core #(.DATA_W(DW), .PC_W(PW), .NREG(8), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .out(out), .flags(flags), .halted(halted), .stack_err(stack_err)
  );

  assign imem_data = mem[imem_addr];

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case something wedges the run
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] i_rr(int op, int rd, int rs);
    return 16'((op << 12) | (rd << 9) | (rs << 6));
  endfunction
  function automatic logic [15:0] i_ldi(int rd, int imm);
    return 16'((6 << 12) | (rd << 9) | (imm & 255));
  endfunction
  function automatic logic [15:0] i_j(int op, int t);
    return 16'((op << 12) | (t & (NADDR - 1)));
  endfunction

  function automatic int sgn(int x);
    return (x >= HALF) ? x - (1 << DW) : x;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_c = 0; m_z = 0; m_s = 0; m_v = 0;
    m_out = 0; m_halt = 0; m_err = 0;
    m_stk.delete();
    m_fpc = 0; m_exa = 0; m_exv = 0;
  endtask

  task automatic set_res(int rd, int res);
    m_z = (res == 0); m_s = (res >= HALF);
    m_r[rd] = res; m_out = res;
  endtask

  // Architectural execution of the instruction in the execute slot, then fetch
  task automatic model_edge();
    int ins, op, rd, rs, a, b, s, ss, npc, taken;
    if (m_halt != 0) return;
    taken = 0; npc = 0;
    if (m_exv != 0) begin
      ins = int'(mem[m_exa]);
      op = ins >> 12; rd = (ins >> 9) & 7; rs = (ins >> 6) & 7;
      a = m_r[rd]; b = m_r[rs];
      case (op)
        1: begin
          s = a + b; ss = sgn(a) + sgn(b);
          m_c = (s > MASK); m_v = (ss > HALF - 1) || (ss < -HALF);
          set_res(rd, s & MASK);
        end
        2: begin
          s = a - b; ss = sgn(a) - sgn(b);
          m_c = (a < b); m_v = (ss > HALF - 1) || (ss < -HALF);
          set_res(rd, s & MASK);
        end
        3: begin m_c = 0; m_v = 0; set_res(rd, a & b); end
        4: begin m_c = 0; m_v = 0; set_res(rd, a | b); end
        5: begin m_c = 0; m_v = 0; set_res(rd, a ^ b); end
        6: begin m_r[rd] = ins & 255; m_out = ins & 255; end
        7: begin m_r[rd] = b; m_out = b; end
        8: begin taken = 1; npc = ins & (NADDR - 1); end
        9: if (m_z != 0) begin taken = 1; npc = ins & (NADDR - 1); end
        10: if (m_z == 0) begin taken = 1; npc = ins & (NADDR - 1); end
        11: if (m_c != 0) begin taken = 1; npc = ins & (NADDR - 1); end
        12: if (m_stk.size() == DEPTH) begin m_halt = 1; m_err = 1; end
            else begin
              m_stk.push_back((m_exa + 1) % NADDR);
              taken = 1; npc = ins & (NADDR - 1);
            end
        13: if (m_stk.size() == 0) begin m_halt = 1; m_err = 1; end
            else begin taken = 1; npc = m_stk.pop_back() % NADDR; end
        14: if (m_stk.size() == DEPTH) begin m_halt = 1; m_err = 1; end
            else m_stk.push_back(b);
        15: if ((ins & 1) != 0) m_halt = 1;
            else if (m_stk.size() == 0) begin m_halt = 1; m_err = 1; end
            else begin m_r[rd] = m_stk.pop_back(); m_out = m_r[rd]; end
        default: ;
      endcase
    end
    if (m_halt != 0) return;
    if (taken != 0) begin
      m_fpc = npc; m_exv = 0;
    end else begin
      m_exa = m_fpc; m_exv = 1; m_fpc = (m_fpc + 1) % NADDR;
    end
  endtask

  task automatic compare(string tag);
    check({tag, ".addr"}, 32'(imem_addr), 32'(m_fpc));
    check({tag, ".out"}, 32'(out), 32'(m_out));
    check({tag, ".flags"}, 32'(flags), 32'((m_c << 3) | (m_z << 2) | (m_s << 1) | m_v));
    check({tag, ".halted"}, 32'(halted), 32'(m_halt));
    check({tag, ".stack_err"}, 32'(stack_err), 32'(m_err));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare(tag);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NADDR; i++) mem[i] = 16'h0000;
  endtask

  // Enter reset, load program via caller afterwards, then release
  task automatic enter_reset(string tag);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare(tag);
    clear_mem();
  endtask

  task automatic leave_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    clear_mem();
    model_reset();
    #2 rst_n = 1'b0;

    // T1: reset values and first results
    enter_reset("t1rst");
    check("t1.rst_addr", 32'(imem_addr), 32'd0);
    check("t1.rst_out", 32'(out), 32'd0);
    check("t1.rst_flags", 32'(flags), 32'd0);
    mem[0] = i_ldi(1, 5); mem[1] = i_ldi(2, 3); mem[2] = i_rr(1, 1, 2);
    leave_reset();
    step("t1");
    step("t1"); check("t1.out5", 32'(out), 32'd5);
    step("t1"); check("t1.out3", 32'(out), 32'd3);
    step("t1"); check("t1.out8", 32'(out), 32'd8);

    // T2: taken branch flushes the shadow instruction
    enter_reset("t2rst");
    mem[0] = i_ldi(1, 1); mem[1] = i_rr(2, 1, 1); mem[2] = i_j(9, 6); mem[3] = i_ldi(3, 8'hFF);
    leave_reset();
    step("t2"); check("t2.addr1", 32'(imem_addr), 32'd1);
    step("t2"); check("t2.addr2", 32'(imem_addr), 32'd2);
    step("t2"); check("t2.addr3", 32'(imem_addr), 32'd3);
    step("t2"); check("t2.addr6", 32'(imem_addr), 32'd6);
    check("t2.z", 32'(flags[2]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step("t2");
      check("t2.no_ff", 32'(out == 8'hFF), 32'd0);
    end

    // T3: nested call / return, then a POP proves the stack is empty again
    enter_reset("t3rst");
    mem[0] = i_j(12, 8); mem[8] = i_j(12, 12); mem[12] = i_j(13, 0); mem[9] = i_j(13, 0);
    mem[1] = i_rr(15, 0, 0);
    leave_reset();
    for (int i = 1; i <= 10; i++) begin
      step("t3");
      if (i == 6) check("t3.ret9", 32'(imem_addr), 32'd9);
      if (i == 8) begin
        check("t3.ret1", 32'(imem_addr), 32'd1);
        check("t3.noerr", 32'(stack_err), 32'd0);
      end
    end
    check("t3.underflow", 32'(stack_err), 32'd1);

    // T4: overflow on the third push freezes the core
    enter_reset("t4rst");
    mem[0] = i_rr(14, 0, 1); mem[1] = i_rr(14, 0, 2); mem[2] = i_rr(14, 0, 3);
    leave_reset();
    for (int i = 0; i < 4; i++) step("t4");
    check("t4.halted", 32'(halted), 32'd1);
    check("t4.err", 32'(stack_err), 32'd1);
    check("t4.addr", 32'(imem_addr), 32'd3);
    step("t4"); step("t4");
    check("t4.frozen", 32'(imem_addr), 32'd3);
    enter_reset("t4brst");
    mem[0] = i_rr(15, 2, 0);
    leave_reset();
    step("t4b"); step("t4b");
    check("t4b.err", 32'(stack_err), 32'd1);

    // T5: 8-bit flags and PC wrap
    enter_reset("t5rst");
    mem[0] = i_ldi(1, 8'h7F); mem[1] = i_ldi(2, 1); mem[2] = i_rr(1, 1, 2); mem[3] = i_rr(2, 2, 1);
    leave_reset();
    for (int i = 1; i <= 33; i++) begin
      step("t5");
      if (i == 4) begin
        check("t5.out80", 32'(out), 32'h80);
        check("t5.flags", 32'(flags), 32'b0011);
      end
      if (i == 5) begin
        check("t5.out81", 32'(out), 32'h81);
        check("t5.c", 32'(flags[3]), 32'd1);
      end
      if (i == 32) check("t5.wrap", 32'(imem_addr), 32'd0);
    end

    // T6: reset while CALL is in EX
    enter_reset("t6rst");
    mem[0] = i_j(12, 5); mem[5] = i_ldi(4, 9);
    leave_reset();
    step("t6");
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6.addr0", 32'(imem_addr), 32'd0);
    compare("t6mid");
    leave_reset();
    for (int i = 0; i < 6; i++) step("t6run");
    check("t6.err", 32'(stack_err), 32'd0);

    // Random programs against the model
    for (int p = 0; p < 6; p++) begin
      enter_reset("rndrst");
      for (int a = 0; a < NADDR; a++) begin
        w = 16'($urandom);
        if (w[15:12] >= 4'hC && $urandom_range(0, 3) != 0) w[15:12] = 4'($urandom_range(1, 7));
        if (w[15:12] == 4'hF && $urandom_range(0, 1) != 0) w[0] = 1'b0;
        mem[a] = w;
      end
      leave_reset();
      for (int c = 0; c < 50; c++) step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
